// File: rtl/doorlock_seq_ctrl.sv
// Door lock sequencing FSM: password entry and comparison, door-open timing,
// password change, consecutive-error counting and alarm lockout.
module doorlock_seq_ctrl #(
    parameter int MAX_DIGITS    = 8,
    parameter int MIN_DIGITS    = 4,
    parameter int MAX_ERRORS    = 3,
    parameter int OPEN_CYCLES   = 1000,
    parameter int LOCK_CYCLES   = 3000,
    parameter int ENTRY_TIMEOUT = 2000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       num_valid,
    input  logic [3:0] num_value,
    input  logic       confirm,
    input  logic       long_confirm,
    output logic       door_open,
    output logic       alarm,
    output logic       err_pulse,
    output logic       set_mode,
    output logic [3:0] entry_len,
    output logic [1:0] err_count,
    output logic [2:0] state_o
);

    localparam int MAX_OL = (OPEN_CYCLES > LOCK_CYCLES) ? OPEN_CYCLES : LOCK_CYCLES;
    localparam int MAX_T  = (MAX_OL > ENTRY_TIMEOUT) ? MAX_OL : ENTRY_TIMEOUT;
    localparam int TIM_W  = $clog2(MAX_T) + 1;
    localparam int LEN_W  = $clog2(MAX_DIGITS) + 1;
    localparam int IDX_W  = $clog2(MAX_DIGITS);
    localparam int ERR_W  = $clog2(MAX_ERRORS) + 1;

    localparam logic [TIM_W-1:0] OPEN_LAST = TIM_W'(OPEN_CYCLES - 1);
    localparam logic [TIM_W-1:0] LOCK_LAST = TIM_W'(LOCK_CYCLES - 1);
    localparam logic [TIM_W-1:0] TO_LAST   = TIM_W'(ENTRY_TIMEOUT - 1);
    localparam logic [LEN_W-1:0] MAX_LEN   = LEN_W'(MAX_DIGITS);
    localparam logic [LEN_W-1:0] MIN_LEN   = LEN_W'(MIN_DIGITS);
    localparam logic [ERR_W-1:0] ERR_MAX   = ERR_W'(MAX_ERRORS);

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_ENTRY     = 3'd1,
        ST_OPEN      = 3'd2,
        ST_SET_ENTRY = 3'd3,
        ST_LOCKOUT   = 3'd4
    } state_t;

    state_t           state_q, state_d;
    logic [3:0]       buf_q [MAX_DIGITS];
    logic [3:0]       buf_d [MAX_DIGITS];
    logic [3:0]       pw_q  [MAX_DIGITS];
    logic [3:0]       pw_d  [MAX_DIGITS];
    logic [LEN_W-1:0] len_q, len_d;
    logic [LEN_W-1:0] pw_len_q, pw_len_d;
    logic [ERR_W-1:0] err_q, err_d;
    logic [TIM_W-1:0] timer_q, timer_d;
    logic             err_pulse_q, err_pulse_d;
    logic             door_open_q, alarm_q, set_mode_q;
    logic             dig_ok;
    logic             pw_match;

    // Confirm outranks long-confirm, which outranks a digit strobe in the same cycle.
    assign dig_ok = num_valid && !confirm && !long_confirm
                    && (num_value <= 4'd9) && (len_q < MAX_LEN);

    always_comb begin
        pw_match = (len_q == pw_len_q);
        for (int i = 0; i < MAX_DIGITS; i++) begin
            if ((LEN_W'(i) < len_q) && (buf_q[i] != pw_q[i])) begin
                pw_match = 1'b0;
            end
        end
    end

    always_comb begin
        // NOTE: every variable gets its hold value first so no path infers a latch.
        state_d     = state_q;
        buf_d       = buf_q;
        pw_d        = pw_q;
        len_d       = len_q;
        pw_len_d    = pw_len_q;
        err_d       = err_q;
        timer_d     = timer_q;
        err_pulse_d = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (dig_ok) begin
                    buf_d[len_q[IDX_W-1:0]] = num_value;
                    len_d   = len_q + 1'b1;
                    timer_d = '0;
                    state_d = ST_ENTRY;
                end
            end

            ST_ENTRY, ST_SET_ENTRY: begin
                if (confirm) begin
                    len_d   = '0;
                    timer_d = '0;
                    if (state_q == ST_ENTRY) begin
                        if (pw_match) begin
                            err_d   = '0;
                            state_d = ST_OPEN;
                        end else begin
                            err_pulse_d = 1'b1;
                            if (err_q + 1'b1 >= ERR_MAX) begin
                                err_d   = ERR_MAX;
                                state_d = ST_LOCKOUT;
                            end else begin
                                err_d   = err_q + 1'b1;
                                state_d = ST_IDLE;
                            end
                        end
                    end else if (len_q >= MIN_LEN) begin
                        pw_d     = buf_q;
                        pw_len_d = len_q;
                        state_d  = ST_IDLE;
                    end else begin
                        // Too-short new password: reject but stay in set mode.
                        err_pulse_d = 1'b1;
                    end
                end else if (long_confirm) begin
                    len_d   = '0;
                    timer_d = '0;
                    state_d = ST_IDLE;
                end else if (dig_ok) begin
                    buf_d[len_q[IDX_W-1:0]] = num_value;
                    len_d   = len_q + 1'b1;
                    timer_d = '0;
                end else if (timer_q == TO_LAST) begin
                    len_d   = '0;
                    timer_d = '0;
                    state_d = ST_IDLE;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end

            ST_OPEN: begin
                if (confirm) begin
                    timer_d = '0;
                    state_d = ST_IDLE;
                end else if (long_confirm) begin
                    timer_d = '0;
                    len_d   = '0;
                    state_d = ST_SET_ENTRY;
                end else if (timer_q == OPEN_LAST) begin
                    timer_d = '0;
                    state_d = ST_IDLE;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end

            ST_LOCKOUT: begin
                if (timer_q == LOCK_LAST) begin
                    timer_d = '0;
                    err_d   = '0;
                    state_d = ST_IDLE;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end

            default: begin
                timer_d = '0;
                len_d   = '0;
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            len_q       <= '0;
            pw_len_q    <= LEN_W'(4);
            err_q       <= '0;
            timer_q     <= '0;
            err_pulse_q <= 1'b0;
            door_open_q <= 1'b0;
            alarm_q     <= 1'b0;
            set_mode_q  <= 1'b0;
            // NOTE: the password store is reset because rst must restore the default 1,2,3,4.
            for (int i = 0; i < MAX_DIGITS; i++) begin
                buf_q[i] <= 4'd0;
                pw_q[i]  <= (i < 4) ? 4'(i + 1) : 4'd0;
            end
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            state_q     <= state_d;
            buf_q       <= buf_d;
            pw_q        <= pw_d;
            len_q       <= len_d;
            pw_len_q    <= pw_len_d;
            err_q       <= err_d;
            timer_q     <= timer_d;
            err_pulse_q <= err_pulse_d;
            door_open_q <= (state_d == ST_OPEN);
            alarm_q     <= (state_d == ST_LOCKOUT);
            set_mode_q  <= (state_d == ST_SET_ENTRY);
        end
    end

    assign door_open = door_open_q;
    assign alarm     = alarm_q;
    assign err_pulse = err_pulse_q;
    assign set_mode  = set_mode_q;
    assign entry_len = len_q;
    assign err_count = err_q[1:0];
    assign state_o   = state_q;

endmodule
